// File: rtl/inv_fade_mixer.sv
// inv_fade_mixer
//   Output mixer for the HDMI dark-mode path. It selects a pixel source,
//   inverts it or passes it through according to the mode and the per-block
//   dark decision, and turns a mode change into a frame-synchronous crossfade.
//   The data path is a fixed 3-stage pipeline. Syncs travel through it
//   alongside the data.
//
//   Build option: define INV_FADE_EN to enable the crossfade (FADE state,
//   per-channel weighting and rounding). When it is undefined, a mode change
//   takes effect at the next frame start, S2/S3 are plain delay stages, and
//   fading_o is tied low.
//
//   Ports
//     clk_i        pixel clock
//     rst_i        synchronous active-high reset
//     mode_i       00 auto, 01 never invert, 10 always invert, 11 auto-inverted
//     blk_x_i      per-pixel block dark decision, aligned with the data inputs
//     src_sel_i    1: vin_data_i, 0: vout_data_i
//     hs_i/vs_i/de_i     input syncs
//     vin_data_i   input pixel, NCH channels of CW bits
//     vout_data_i  alternate (loop-back) pixel
//     hs_o/vs_o/de_o     syncs delayed 3 cycles
//     data_o       mixed pixel, 3-cycle latency
//     inv_o        new-mode invert decision for the pixel on data_o
//     fading_o     high while a crossfade is in progress
module inv_fade_mixer #(
    parameter int CW        = 8,
    parameter int NCH       = 3,
    parameter int FADE_LOG2 = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              blk_x_i,
    input  logic              src_sel_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [NCH*CW-1:0] vin_data_i,
    input  logic [NCH*CW-1:0] vout_data_i,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic [NCH*CW-1:0] data_o,
    output logic              inv_o,
    output logic              fading_o
);

    localparam int         DW        = NCH * CW;
    localparam logic [1:0] MODE_PASS = 2'b01;

    function automatic logic inv_of(input logic [1:0] m, input logic bx);
        case (m)
            2'b00:   return bx;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~bx;
        endcase
    endfunction

    function automatic logic [DW-1:0] px_of(input logic [1:0] m, input logic bx,
                                            input logic [DW-1:0] p);
        return p ^ {DW{inv_of(m, bx)}};
    endfunction

    logic          vs_q;
    logic          vs_rise;
    logic [DW-1:0] pix;
    logic [1:0]    cur_mode_q;
    logic [DW-1:0] data_p2;

    assign vs_rise = vs_i & ~vs_q;
    assign pix     = src_sel_i ? vin_data_i : vout_data_i;

    // vs_q keeps tracking vs_i while reset is asserted. A vs_i level held high
    // across reset deassertion is therefore not seen as a frame start.
    always_ff @(posedge clk_i) begin
        vs_q <= vs_i;
    end

    logic hs_p0, vs_p0, vld_p0, inv_p0;
    logic hs_p1, vs_p1, vld_p1, inv_p1;
    logic hs_p2, vs_p2, vld_p2, inv_p2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_p0 <= 1'b0; vs_p0 <= 1'b0; vld_p0 <= 1'b0; inv_p0 <= 1'b0;
            hs_p1 <= 1'b0; vs_p1 <= 1'b0; vld_p1 <= 1'b0; inv_p1 <= 1'b0;
            hs_p2 <= 1'b0; vs_p2 <= 1'b0; vld_p2 <= 1'b0; inv_p2 <= 1'b0;
        end else begin
            // S1
            hs_p0  <= hs_i;
            vs_p0  <= vs_i;
            vld_p0 <= de_i;
            inv_p0 <= inv_of(cur_mode_q, blk_x_i);
            // S2
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            vld_p1 <= vld_p0;
            inv_p1 <= inv_p0;
            // S3
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
            inv_p2 <= inv_p1;
        end
    end

    assign hs_o   = hs_p2;
    assign vs_o   = vs_p2;
    assign de_o   = vld_p2;
    assign inv_o  = inv_p2;
    assign data_o = data_p2;

`ifdef INV_FADE_EN
    localparam int                   PW     = CW + FADE_LOG2;
    localparam int                   F      = 1 << FADE_LOG2;
    localparam logic [FADE_LOG2-1:0] A_LAST = '1;

    typedef enum logic {IDLE, FADE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cur_mode_d;
    logic [1:0]           old_mode_q, old_mode_d;
    logic [FADE_LOG2-1:0] a_q, a_d;

    // Channel value times weight. The product is at most (2^CW-1)*2^FADE_LOG2,
    // so it always fits in PW bits.
    function automatic logic [PW-1:0] weigh(input logic [CW-1:0] c,
                                            input logic [FADE_LOG2:0] w);
        logic [PW-1:0] prod;
        prod = PW'(c) * PW'(w);
        return prod;
    endfunction

    // Round half up, divide by F, and clamp to full scale.
    function automatic logic [CW-1:0] round_sat(input logic [PW:0] sum);
        logic [PW:0] q;
        q = (sum + (PW+1)'(F / 2)) >> FADE_LOG2;
        if (q > (PW+1)'({CW{1'b1}})) return {CW{1'b1}};
        return q[CW-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_mode_q <= MODE_PASS;
            old_mode_q <= MODE_PASS;
            a_q        <= '0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            old_mode_q <= old_mode_d;
            a_q        <= a_d;
        end
    end

    // Mode and alpha move only at a frame start, so a whole frame is mixed
    // with a single weight.
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        old_mode_d = old_mode_q;
        a_d        = a_q;
        case (state_q)
            IDLE: begin
                if (vs_rise && (mode_i != cur_mode_q)) begin
                    old_mode_d = cur_mode_q;
                    cur_mode_d = mode_i;
                    a_d        = FADE_LOG2'(1);
                    state_d    = FADE;
                end
            end
            FADE: begin
                if (vs_rise) begin
                    if (a_q == A_LAST) begin
                        a_d        = '0;
                        old_mode_d = cur_mode_q;
                        state_d    = IDLE;
                    end else begin
                        a_d = a_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fading_o = (state_q == FADE);

    logic [DW-1:0]             o_p0, n_p0;
    logic [FADE_LOG2-1:0]      a_p0;
    logic [FADE_LOG2:0]        w_old, w_new;
    logic [NCH-1:0][PW-1:0]    wo_d, wn_d, wo_p1, wn_p1;
    logic [DW-1:0]             mix_d;

    // Alpha travels with the pixel. A frame start while pixels are in flight
    // does not change the weight those pixels are mixed with.
    assign w_new = {1'b0, a_p0};
    assign w_old = (FADE_LOG2+1)'(F) - w_new;

    always_comb begin
        wo_d = '0;
        wn_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            wo_d[ch] = weigh(o_p0[ch*CW +: CW], w_old);
            wn_d[ch] = weigh(n_p0[ch*CW +: CW], w_new);
        end
    end

    always_comb begin
        mix_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            mix_d[ch*CW +: CW] = round_sat({1'b0, wo_p1[ch]} + {1'b0, wn_p1[ch]});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_p0    <= '0;
            n_p0    <= '0;
            a_p0    <= '0;
            wo_p1   <= '0;
            wn_p1   <= '0;
            data_p2 <= '0;
        end else begin
            // S1
            o_p0    <= px_of(old_mode_q, blk_x_i, pix);
            n_p0    <= px_of(cur_mode_q, blk_x_i, pix);
            a_p0    <= a_q;
            // S2
            wo_p1   <= wo_d;
            wn_p1   <= wn_d;
            // S3
            data_p2 <= mix_d;
        end
    end
`else
    logic [DW-1:0] n_p0, n_p1;
    logic          unused_fade_cfg;

    assign unused_fade_cfg = (FADE_LOG2 > 0);
    assign fading_o        = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_mode_q <= MODE_PASS;
        end else if (vs_rise) begin
            cur_mode_q <= mode_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_p0    <= '0;
            n_p1    <= '0;
            data_p2 <= '0;
        end else begin
            // S1
            n_p0    <= px_of(cur_mode_q, blk_x_i, pix);
            // S2
            n_p1    <= n_p0;
            // S3
            data_p2 <= n_p1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_fade_mixer.sv
// Self-checking bench for inv_fade_mixer. A behavioural model tracks the
// mode/alpha state per frame and computes each mixed pixel arithmetically.
// Expected outputs wait in a queue until the pipeline delivers them.
module tb_inv_fade_mixer;
    localparam int CW        = 8;
    localparam int NCH       = 3;
    localparam int FADE_LOG2 = 4;
    localparam int DW        = NCH * CW;
    localparam int F         = 1 << FADE_LOG2;
    localparam int PMAX      = (1 << CW) - 1;
    localparam int FLEN      = 10;
`ifdef INV_FADE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    mode_i;
    logic          blk_x_i, src_sel_i, hs_i, vs_i, de_i;
    logic [DW-1:0] vin_data_i, vout_data_i;
    logic          hs_o, vs_o, de_o, inv_o, fading_o;
    logic [DW-1:0] data_o;

    always #5 clk_i = ~clk_i;

    inv_fade_mixer #(.CW(CW), .NCH(NCH), .FADE_LOG2(FADE_LOG2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .blk_x_i(blk_x_i),
        .src_sel_i(src_sel_i), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
        .vin_data_i(vin_data_i), .vout_data_i(vout_data_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o),
        .inv_o(inv_o), .fading_o(fading_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: current/previous mode, alpha, fade flag, last vs level.
    int m_cur, m_old, m_alpha;
    bit m_fading, m_vs_prev;

    typedef logic [DW+3:0] obs_t;  // {hs, vs, de, inv, data}
    obs_t exp_q[$];
    obs_t got_obs, exp_obs;
    logic got_fading;
    bit   exp_fading;

    function automatic bit inv_for(input int m, input bit bx);
        case (m)
            0:       return bx;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return !bx;
        endcase
    endfunction

    function automatic logic [DW-1:0] mix_ref(input int om, input int nm, input int a,
                                              input bit bx, input logic [DW-1:0] p);
        logic [DW-1:0] r;
        int pc, o, n, v;
        r = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            pc = int'(p[ch*CW +: CW]);
            o  = inv_for(om, bx) ? PMAX - pc : pc;
            n  = inv_for(nm, bx) ? PMAX - pc : pc;
            v  = (o * (F - a) + n * a + F / 2) / F;
            if (v > PMAX) v = PMAX;
            r[ch*CW +: CW] = v[CW-1:0];
        end
        return r;
    endfunction

    // One clock: drive inputs, advance the model, then sample the outputs.
    task automatic cycle(input bit rst, input logic [1:0] mode, input bit bx, input bit src,
                         input bit hs, input bit vs, input bit de,
                         input logic [DW-1:0] vin, input logic [DW-1:0] vout);
        logic [DW-1:0] p;
        bit rise;
        @(negedge clk_i);
        rst_i = rst; mode_i = mode; blk_x_i = bx; src_sel_i = src;
        hs_i = hs; vs_i = vs; de_i = de; vin_data_i = vin; vout_data_i = vout;
        if (rst) begin
            m_cur = 1; m_old = 1; m_alpha = 0; m_fading = 1'b0; m_vs_prev = vs;
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            exp_obs = '0;
        end else begin
            p = src ? vin : vout;
            exp_q.push_back({hs, vs, de, inv_for(m_cur, bx), mix_ref(m_old, m_cur, m_alpha, bx, p)});
            rise = vs && !m_vs_prev;
            m_vs_prev = vs;
            if (rise) begin
`ifdef INV_FADE_EN
                if (m_fading) begin
                    m_alpha++;
                    if (m_alpha == F) begin
                        m_alpha = 0; m_old = m_cur; m_fading = 1'b0;
                    end
                end else if (mode != m_cur) begin
                    m_old = m_cur; m_cur = mode; m_alpha = 1; m_fading = 1'b1;
                end
`else
                m_cur = mode; m_old = mode;
`endif
            end
            exp_obs = exp_q.pop_front();
        end
        exp_fading = m_fading;
        @(posedge clk_i);
        #1;
        got_obs    = {hs_o, vs_o, de_o, inv_o, data_o};
        got_fading = fading_o;
    endtask

    task automatic run_frame(input logic [1:0] m0, input logic [1:0] m1, input int sw,
                             input string tag);
        logic [1:0] m;
        for (int i = 0; i < FLEN; i++) begin
            m = (i < sw) ? m0 : m1;
            cycle(1'b0, m, 1'($urandom), 1'($urandom), (i % 4) == 0, i < 2, i >= 3,
                  DW'($urandom), DW'($urandom));
            n_cmp++;
            if (got_obs !== exp_obs) begin
                n_bad++;
                $display("FAIL %s_out[%0d]: got %h want %h", tag, i, got_obs, exp_obs);
            end
            n_cmp++;
            if (got_fading !== exp_fading) begin
                n_bad++;
                $display("FAIL %s_fading[%0d]: got %b want %b", tag, i, got_fading, exp_fading);
            end
        end
    endtask

    task automatic const_frame(input logic [1:0] mode, input bit bx, input logic [DW-1:0] pix,
                               input logic [DW-1:0] want, input bit want_fading,
                               input string tag);
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b0, mode, bx, 1'b1, (i % 4) == 0, i < 2, i >= 3, pix, ~pix);
            n_cmp++;
            if (got_obs !== exp_obs) begin
                n_bad++;
                $display("FAIL %s_out[%0d]: got %h want %h", tag, i, got_obs, exp_obs);
            end
        end
        n_cmp++;
        if (got_obs[DW-1:0] !== want) begin
            n_bad++;
            $display("FAIL %s_data: got %h want %h", tag, got_obs[DW-1:0], want);
        end
        n_cmp++;
        if (got_fading !== want_fading) begin
            n_bad++;
            $display("FAIL %s_fading: got %b want %b", tag, got_fading, want_fading);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
        cycle(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic test_reset();
        logic [DW-1:0] want;
        do_reset();
        n_cmp++;
        if (got_obs !== '0 || got_fading !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%b want 0/0", got_obs, got_fading);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                  (i == 0) ? 24'h123456 : 24'h000000, 24'hABCDEF);
            want = (i == 2) ? 24'h123456 : 24'h000000;
            n_cmp++;
            if (got_obs[DW-1:0] !== want || got_obs[DW] !== 1'b0 || got_fading !== 1'b0) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %h inv %b fading %b want %h inv 0 fading 0",
                         i, got_obs[DW-1:0], got_obs[DW], got_fading, want);
            end
        end
    endtask

    task automatic test_fade();
        do_reset();
        run_frame(2'b01, 2'b01, 0, "pre");
        run_frame(2'b01, 2'b10, 5, "midframe");
        const_frame(2'b10, 1'b0, 24'h000000, EN ? 24'h101010 : 24'hFFFFFF, EN, "fade_a1");
        for (int k = 0; k < 14; k++) run_frame(2'b10, 2'b10, 0, "fade");
        const_frame(2'b10, 1'b0, 24'h000000, 24'hFFFFFF, 1'b0, "fade_done");
    endtask

    task automatic test_auto_toggle();
        bit bx_hist[2*FLEN];
        bit bx;
        int hi;
        logic [DW-1:0] want;
        do_reset();
        for (int k = 0; k < 17; k++) run_frame(2'b00, 2'b00, 0, "to_auto");
        for (int i = 0; i < 2 * FLEN; i++) begin
            bx = i[0];
            bx_hist[i] = bx;
            cycle(1'b0, 2'b00, bx, 1'b1, 1'b0, i < 2, 1'b1, 24'h0F0F0F, DW'($urandom));
            if (i >= 2) begin
                hi = i - 2;
                want = bx_hist[hi] ? 24'hF0F0F0 : 24'h0F0F0F;
                n_cmp++;
                if (got_obs[DW-1:0] !== want || got_obs[DW] !== bx_hist[hi]) begin
                    n_bad++;
                    $display("FAIL auto_toggle[%0d]: got %h inv %b want %h inv %b",
                             i, got_obs[DW-1:0], got_obs[DW], want, bx_hist[hi]);
                end
            end
        end
    endtask

    task automatic test_ignore_during_fade();
        do_reset();
        const_frame(2'b10, 1'b1, 24'h000000, EN ? 24'h101010 : 24'hFFFFFF, EN, "ign_a1");
        for (int k = 0; k < 4; k++) run_frame(2'b10, 2'b10, 0, "ign_10");
        for (int k = 0; k < 10; k++) run_frame(2'b11, 2'b11, 0, "ign_11");
        const_frame(2'b11, 1'b1, 24'h000000, EN ? 24'hFFFFFF : 24'h000000, 1'b0, "ign_done");
        const_frame(2'b11, 1'b1, 24'h000000, EN ? 24'hEFEFEF : 24'h000000, EN, "ign_next");
    endtask

    task automatic test_reset_mid_fade();
        do_reset();
        const_frame(2'b10, 1'b0, 24'h000000, EN ? 24'h101010 : 24'hFFFFFF, EN, "rmf_a1");
        for (int k = 0; k < 6; k++) run_frame(2'b10, 2'b10, 0, "rmf");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h123456, 24'h0);
        cycle(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h123456, 24'h0);
        n_cmp++;
        if (got_obs !== '0 || got_fading !== 1'b0) begin
            n_bad++;
            $display("FAIL rmf_reset: got %h/%b want 0/0", got_obs, got_fading);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, i < 5, 1'b1, 24'h123456, 24'h0);
            n_cmp++;
            if (got_fading !== 1'b0 || (i >= 2 && got_obs[DW-1:0] !== 24'h123456)) begin
                n_bad++;
                $display("FAIL rmf_held_vs[%0d]: got %h fading %b want 123456 fading 0",
                         i, got_obs[DW-1:0], got_fading);
            end
            n_cmp++;
            if (got_obs !== exp_obs) begin
                n_bad++;
                $display("FAIL rmf_model[%0d]: got %h want %h", i, got_obs, exp_obs);
            end
        end
        run_frame(2'b10, 2'b10, 0, "rmf_restart");
    endtask

    task automatic test_random();
        logic [1:0] m0, m1;
        do_reset();
        for (int f = 0; f < 24; f++) begin
            m0 = 2'($urandom_range(0, 3));
            m1 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : m0;
            run_frame(m0, m1, $urandom_range(0, FLEN - 1), "rand");
        end
    endtask

    initial begin
        rst_i = 1'b1; mode_i = 2'b01; blk_x_i = 1'b0; src_sel_i = 1'b1;
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; vin_data_i = '0; vout_data_i = '0;
        test_reset();
        test_fade();
        test_auto_toggle();
        test_ignore_during_fade();
        test_reset_mid_fade();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
